turbosound_n: RTL and testbench
===============================

TURBOSOUND_N -- requirements
Module: turbosound_n

Interface
REQ-001 SHALL have parameter NUM_CHIPS, default 2, number of jt03 chip instances; legal values 1, 2, 3 or 4.
REQ-002 SHALL have parameter OUT_W, default 12, output sample width; legal values 12..16.
REQ-003 SHALL have port CLK  input  1  global clock, the only clock.
REQ-004 SHALL have port RESET_N  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port CE  input  1  chip master clock enable, passed to every chip's cen.
REQ-006 SHALL have port BDIR  input  1  bus direction, 1 = write.
REQ-007 SHALL have port BC  input  1  bus control, 1 = address/control phase.
REQ-008 SHALL have port DI  input  8  bus data in.
REQ-009 SHALL have port DO  output  8  read data of the selected chip.
REQ-010 SHALL have port CHANNEL_L  output  OUT_W  signed left mix.
REQ-011 SHALL have port CHANNEL_R  output  OUT_W  signed right mix.

Function
REQ-012 SHALL register BDIR, BC and DI through two CLK stages; all decoding uses the second stage (_s).
REQ-013 SHALL act only on a BDIR_s rising edge, detected against a one-cycle-delayed copy.
REQ-014 On an edge with BC_s=1 and DI_s[7:3]=11111: sel[0]<=~DI_s[0], stat_sel<=DI_s[1], fm_ena<=~DI_s[2], ym_acc<=0, no chip write.
REQ-015 On an edge with BC_s=1 and DI_s[7:3]=11110: sel[1]<=~DI_s[0], pan<=DI_s[2:1], ym_acc<=0, no chip write.
REQ-016 On an edge with any other BC_s=1 value: ym_acc and ym_wr SHALL both be set to (DI_s[7:4]==0)|fm_ena.
REQ-017 On an edge with BC_s=0: ym_wr<=ym_acc.
REQ-018 ym_wr SHALL be a single-CLK pulse; ym_di SHALL latch DI_s on every edge.
REQ-019 Chip addr SHALL be ~BC_s while BDIR_s|ym_wr, else stat_sel; wr_n=~ym_wr; cs_n is low only for chip index sel.
REQ-020 If sel >= NUM_CHIPS, the selected index SHALL saturate to NUM_CHIPS-1; with NUM_CHIPS<=2, sel[1] SHALL read as 0.
REQ-021 DO SHALL be the dout of the selected chip, combinationally.
REQ-022 Mixer stage 1: per PSG channel, unsigned sum over all chips.
REQ-023 Mixer stage 2: each channel sum SHALL saturate to 8'hFF if it exceeds 255.
REQ-024 Mixer stage 3, pan=00 (ABC): L=2A+B, R=2C+B.
REQ-025 Mixer stage 3, pan=01 (ACB): L=2A+C, R=2B+C.
REQ-026 Mixer stage 3, pan=10 (mono): L=R=A+B+C.
REQ-027 Mixer stage 3, pan=11: SHALL behave as ABC.
REQ-028 Mixer stage 3, FM: each fm_snd[15:6] sign-extended, summed to 12 bits signed.
REQ-029 Mixer stage 4: ch = fm_ena ? fm+psg : psg, 12-bit signed, sign-extended to OUT_W.
REQ-030 Latency from chip outputs to CHANNEL_L/R SHALL be exactly 4 CLK; pan/fm_ena changes take effect at stage 3/4 within the same pipeline.
REQ-031 A BDIR_s edge coincident with any mixer update SHALL NOT stall or alter the pipeline.

Reset
REQ-032 RESET_N low SHALL asynchronously set sel=0, stat_sel=1, fm_ena=0, pan=00, ym_acc=0, ym_wr=0, old BDIR=0.
REQ-033 Mixer registers SHALL clear to 0, so CHANNEL_L=CHANNEL_R=0 and DO=dout of chip 0 during reset.
REQ-034 Chip rst SHALL be active-high, asserted asynchronously with RESET_N and released synchronously 2 CLK after RESET_N rises.
REQ-035 Reset mid-write SHALL abort it: no ym_wr pulse after RESET_N falls.

Configuration
REQ-036 Macro TURBOSOUND_FM_EN defined: full behaviour as above.
REQ-037 Macro TURBOSOUND_FM_EN undefined: fm_ena held 0, DI_s[2] ignored, FM summation removed, addresses >=0x10 never written, mix = PSG only.

Verification
REQ-038 Release reset, write control 0xFF, then addr 0x08 and data 0x0F -> exactly one ym_wr pulse to chip 0, addr 0x08, data 0x0F.
REQ-039 NUM_CHIPS=4: write 0xF6, then 0xFE -> sel=3; a register 0x07 write reaches chip 3 only; DO follows chip 3.
REQ-040 fm_ena=0: address 0x28 then data -> no ym_wr; control 0xFB then 0x28 -> write occurs.
REQ-041 Force PSG A=0xC0 on two chips, B=C=0, pan=00 -> CHANNEL_L=0x1FE, CHANNEL_R=0, 4 CLK after stimulus.
REQ-042 pan=10 with A=B=C=0x10 -> L=R=0x030; fm_ena=1 with each fm_snd=16'h8000 (NUM_CHIPS=2) -> L=0x030-0x400=12'hC30.
REQ-043 Assert RESET_N low between address and data phases -> no write, outputs 0, sel=0, pan=00.

Source files
------------

// File: rtl/turbosound_n.sv
// TurboSound-style bus front end driving up to four jt03 chips, with a 4-stage stereo mixer.
// Optional feature macro: TURBOSOUND_FM_EN enables FM register access and FM mixing.

module turbosound_n #(
    parameter int NUM_CHIPS = 2,
    parameter int OUT_W     = 12
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    CE,
    input  logic                    BDIR,
    input  logic                    BC,
    input  logic [7:0]              DI,
    output logic [7:0]              DO,
    output logic signed [OUT_W-1:0] CHANNEL_L,
    output logic signed [OUT_W-1:0] CHANNEL_R
);

    typedef enum logic [1:0] {
        PAN_ABC  = 2'b00,
        PAN_ACB  = 2'b01,
        PAN_MONO = 2'b10,
        PAN_ABC2 = 2'b11
    } pan_e;

    localparam logic [1:0] MAX_IDX = 2'(NUM_CHIPS - 1);

    logic       bdir_m_q, bdir_s_q, bdir_old_q;
    logic       bc_m_q, bc_s_q;
    logic [7:0] di_m_q, di_s_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            bdir_m_q   <= 1'b0;
            bdir_s_q   <= 1'b0;
            bdir_old_q <= 1'b0;
            bc_m_q     <= 1'b0;
            bc_s_q     <= 1'b0;
            di_m_q     <= '0;
            di_s_q     <= '0;
        end else begin
            bdir_m_q   <= BDIR;
            bdir_s_q   <= bdir_m_q;
            bdir_old_q <= bdir_s_q;
            bc_m_q     <= BC;
            bc_s_q     <= bc_m_q;
            di_m_q     <= DI;
            di_s_q     <= di_m_q;
        end
    end

    logic bdir_rise;
    assign bdir_rise = bdir_s_q & ~bdir_old_q;

    logic [1:0] sel_q, sel_d;
    logic       stat_sel_q, stat_sel_d;
    logic       fm_ena_q, fm_ena_d;
    logic       ym_acc_q, ym_acc_d;
    logic       ym_wr_q, ym_wr_d;
    pan_e       pan_q, pan_d;
    logic [7:0] ym_di_q, ym_di_d;

    always_comb begin
        sel_d      = sel_q;
        stat_sel_d = stat_sel_q;
        fm_ena_d   = fm_ena_q;
        ym_acc_d   = ym_acc_q;
        pan_d      = pan_q;
        ym_di_d    = ym_di_q;
        ym_wr_d    = 1'b0;
        if (bdir_rise) begin
            ym_di_d = di_s_q;
            if (!bc_s_q) begin
                ym_wr_d = ym_acc_q;
            end else if (di_s_q[7:3] == 5'b11111) begin
                sel_d[0]   = ~di_s_q[0];
                stat_sel_d = di_s_q[1];
`ifdef TURBOSOUND_FM_EN
                fm_ena_d   = ~di_s_q[2];
`endif
                ym_acc_d   = 1'b0;
            end else if (di_s_q[7:3] == 5'b11110) begin
                sel_d[1] = ~di_s_q[0];
                pan_d    = pan_e'(di_s_q[2:1]);
                ym_acc_d = 1'b0;
            end else begin
                // Without FM, fm_ena stays 0 so only PSG addresses 0x00-0x0F are accepted.
                ym_acc_d = (di_s_q[7:4] == 4'h0) | fm_ena_q;
                ym_wr_d  = ym_acc_d;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sel_q      <= '0;
            stat_sel_q <= 1'b1;
            fm_ena_q   <= 1'b0;
            ym_acc_q   <= 1'b0;
            ym_wr_q    <= 1'b0;
            pan_q      <= PAN_ABC;
            ym_di_q    <= '0;
        end else begin
            sel_q      <= sel_d;
            stat_sel_q <= stat_sel_d;
            fm_ena_q   <= fm_ena_d;
            ym_acc_q   <= ym_acc_d;
            ym_wr_q    <= ym_wr_d;
            pan_q      <= pan_d;
            ym_di_q    <= ym_di_d;
        end
    end

    // Chip reset: asserted with RESET_N, released two clocks after it rises.
    logic [1:0] chip_rst_q;
    logic       chip_rst;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) chip_rst_q <= 2'b11;
        else          chip_rst_q <= {chip_rst_q[0], 1'b0};
    end
    assign chip_rst = chip_rst_q[1];

    logic [1:0] sel_m, sel_idx;

    always_comb begin
        sel_m = sel_q;
        if (NUM_CHIPS <= 2) sel_m[1] = 1'b0;
        sel_idx = (sel_m > MAX_IDX) ? MAX_IDX : sel_m;
    end

    logic chip_addr;
    assign chip_addr = (bdir_s_q | ym_wr_q) ? ~bc_s_q : stat_sel_q;

    logic [7:0]  chip_dout [4];
    logic [7:0]  psg_a     [4];
    logic [7:0]  psg_b     [4];
    logic [7:0]  psg_c     [4];
    logic [15:0] fm_snd    [4];

    for (genvar g = 0; g < 4; g++) begin : g_chip
        if (g < NUM_CHIPS) begin : g_inst
            jt03 u_chip (
                .rst    (chip_rst),
                .clk    (CLK),
                .cen    (CE),
                .din    (ym_di_q),
                .addr   (chip_addr),
                .cs_n   (sel_idx != 2'(g)),
                .wr_n   (~ym_wr_q),
                .dout   (chip_dout[g]),
                .psg_A  (psg_a[g]),
                .psg_B  (psg_b[g]),
                .psg_C  (psg_c[g]),
                .fm_snd (fm_snd[g])
            );
        end else begin : g_none
            assign chip_dout[g] = '0;
            assign psg_a[g]     = '0;
            assign psg_b[g]     = '0;
            assign psg_c[g]     = '0;
            assign fm_snd[g]    = '0;
        end
    end

    assign DO = chip_dout[sel_idx];

    logic [9:0] sum_a_d, sum_b_d, sum_c_d, sum_a_q, sum_b_q, sum_c_q;
    logic [7:0] sat_a_d, sat_b_d, sat_c_d, sat_a_q, sat_b_q, sat_c_q;
    logic [9:0] psg_l_d, psg_r_d, psg_l_q, psg_r_q;
    logic signed [11:0] ch_l_d, ch_r_d, ch_l_q, ch_r_q;

    always_comb begin
        sum_a_d = '0;
        sum_b_d = '0;
        sum_c_d = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            sum_a_d = sum_a_d + 10'(psg_a[i]);
            sum_b_d = sum_b_d + 10'(psg_b[i]);
            sum_c_d = sum_c_d + 10'(psg_c[i]);
        end
    end

    always_comb begin
        sat_a_d = (sum_a_q > 10'd255) ? 8'hFF : sum_a_q[7:0];
        sat_b_d = (sum_b_q > 10'd255) ? 8'hFF : sum_b_q[7:0];
        sat_c_d = (sum_c_q > 10'd255) ? 8'hFF : sum_c_q[7:0];
    end

    always_comb begin
        psg_l_d = '0;
        psg_r_d = '0;
        case (pan_q)
            PAN_ACB: begin
                psg_l_d = (10'(sat_a_q) << 1) + 10'(sat_c_q);
                psg_r_d = (10'(sat_b_q) << 1) + 10'(sat_c_q);
            end
            PAN_MONO: begin
                psg_l_d = 10'(sat_a_q) + 10'(sat_b_q) + 10'(sat_c_q);
                psg_r_d = psg_l_d;
            end
            default: begin
                psg_l_d = (10'(sat_a_q) << 1) + 10'(sat_b_q);
                psg_r_d = (10'(sat_c_q) << 1) + 10'(sat_b_q);
            end
        endcase
    end

`ifdef TURBOSOUND_FM_EN
    // FM samples ride two delay stages so they meet the PSG mix at stage 3.
    logic signed [9:0]  fm1_q [4];
    logic signed [9:0]  fm2_q [4];
    logic signed [11:0] fm_sum_d, fm_sum_q;
    logic               unused_fm_lo;

    assign unused_fm_lo = ^{fm_snd[0][5:0], fm_snd[1][5:0], fm_snd[2][5:0], fm_snd[3][5:0]};

    always_comb begin
        fm_sum_d = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            fm_sum_d = fm_sum_d + 12'(fm2_q[i]);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int unsigned i = 0; i < 4; i++) begin
                fm1_q[i] <= '0;
                fm2_q[i] <= '0;
            end
            fm_sum_q <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                fm1_q[i] <= fm_snd[i][15:6];
                fm2_q[i] <= fm1_q[i];
            end
            fm_sum_q <= fm_sum_d;
        end
    end

    always_comb begin
        ch_l_d = signed'({2'b00, psg_l_q});
        ch_r_d = signed'({2'b00, psg_r_q});
        if (fm_ena_q) begin
            ch_l_d = fm_sum_q + ch_l_d;
            ch_r_d = fm_sum_q + ch_r_d;
        end
    end
`else
    logic unused_fm;
    assign unused_fm = ^{fm_snd[0], fm_snd[1], fm_snd[2], fm_snd[3], fm_ena_q};

    always_comb begin
        ch_l_d = signed'({2'b00, psg_l_q});
        ch_r_d = signed'({2'b00, psg_r_q});
    end
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sum_a_q <= '0;
            sum_b_q <= '0;
            sum_c_q <= '0;
            sat_a_q <= '0;
            sat_b_q <= '0;
            sat_c_q <= '0;
            psg_l_q <= '0;
            psg_r_q <= '0;
            ch_l_q  <= '0;
            ch_r_q  <= '0;
        end else begin
            sum_a_q <= sum_a_d;
            sum_b_q <= sum_b_d;
            sum_c_q <= sum_c_d;
            sat_a_q <= sat_a_d;
            sat_b_q <= sat_b_d;
            sat_c_q <= sat_c_d;
            psg_l_q <= psg_l_d;
            psg_r_q <= psg_r_d;
            ch_l_q  <= ch_l_d;
            ch_r_q  <= ch_r_d;
        end
    end

    assign CHANNEL_L = OUT_W'(ch_l_q);
    assign CHANNEL_R = OUT_W'(ch_r_q);

endmodule

// Register-level jt03 stand-in: address latch, 256-byte register file, PSG amplitudes
// from registers 0x08-0x0A and an FM sample from registers 0xB1:0xB0.
module jt03 (
    input  logic               rst,
    input  logic               clk,
    input  logic               cen,
    input  logic [7:0]         din,
    input  logic               addr,
    input  logic               cs_n,
    input  logic               wr_n,
    output logic [7:0]         dout,
    output logic [7:0]         psg_A,
    output logic [7:0]         psg_B,
    output logic [7:0]         psg_C,
    output logic signed [15:0] fm_snd
);

    logic [7:0] regs_q [256];
    logic [7:0] addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 256; i++) regs_q[i] <= '0;
            addr_q <= '0;
        end else if (!cs_n && !wr_n) begin
            if (!addr) addr_q <= din;
            else       regs_q[addr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psg_A  <= '0;
            psg_B  <= '0;
            psg_C  <= '0;
            fm_snd <= '0;
        end else if (cen) begin
            psg_A  <= regs_q[8'h08];
            psg_B  <= regs_q[8'h09];
            psg_C  <= regs_q[8'h0A];
            fm_snd <= signed'({regs_q[8'hB1], regs_q[8'hB0]});
        end
    end

    assign dout = addr ? regs_q[addr_q] : 8'h00;

endmodule

// File: tb/tb_turbosound_n.sv
// Directed self-checking bench for turbosound_n: a 4-chip/12-bit instance and a 2-chip/16-bit
// instance share one bus; expectations follow the TURBOSOUND_FM_EN build setting.

module tb_turbosound_n;

    logic               CLK;
    logic               RESET_N;
    logic               CE;
    logic               BDIR;
    logic               BC;
    logic [7:0]         DI;
    logic [7:0]         do4, do2;
    logic signed [11:0] l4, r4;
    logic signed [15:0] l2, r2;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_pulses = 0;

    turbosound_n #(.NUM_CHIPS(4), .OUT_W(12)) u_dut (
        .CLK(CLK), .RESET_N(RESET_N), .CE(CE), .BDIR(BDIR), .BC(BC), .DI(DI),
        .DO(do4), .CHANNEL_L(l4), .CHANNEL_R(r4)
    );

    turbosound_n #(.NUM_CHIPS(2), .OUT_W(16)) u_dut2 (
        .CLK(CLK), .RESET_N(RESET_N), .CE(CE), .BDIR(BDIR), .BC(BC), .DI(DI),
        .DO(do2), .CHANNEL_L(l2), .CHANNEL_R(r2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) if (u_dut.ym_wr_q === 1'b1) wr_pulses <= wr_pulses + 1;

    task automatic bus_cycle(input logic bc, input logic [7:0] d);
        @(negedge CLK);
        BC = bc;
        DI = d;
        repeat (2) @(negedge CLK);
        BDIR = 1'b1;
        repeat (4) @(negedge CLK);
        BDIR = 1'b0;
        repeat (8) @(negedge CLK);
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        bus_cycle(1'b1, a);
        bus_cycle(1'b0, d);
    endtask

    task automatic test_reset;
        RESET_N = 1'b1;
        #3 RESET_N = 1'b0;
        repeat (4) @(negedge CLK);
        n_checks++; if (l4 !== 12'h000) $display("FAIL reset_l: got %h want 000", l4); else n_pass++;
        n_checks++; if (r4 !== 12'h000) $display("FAIL reset_r: got %h want 000", r4); else n_pass++;
        n_checks++; if (do4 !== 8'h00) $display("FAIL reset_do: got %h want 00", do4); else n_pass++;
        n_checks++; if (u_dut.sel_q !== 2'b00) $display("FAIL reset_sel: got %b want 00", u_dut.sel_q); else n_pass++;
        n_checks++; if (u_dut.stat_sel_q !== 1'b1) $display("FAIL reset_stat_sel: got %b want 1", u_dut.stat_sel_q); else n_pass++;
        n_checks++; if (u_dut.chip_rst !== 1'b1) $display("FAIL reset_chip_rst_held: got %b want 1", u_dut.chip_rst); else n_pass++;
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        n_checks++; if (u_dut.chip_rst !== 1'b1) $display("FAIL chip_rst_1clk: got %b want 1", u_dut.chip_rst); else n_pass++;
        @(negedge CLK);
        n_checks++; if (u_dut.chip_rst !== 1'b0) $display("FAIL chip_rst_2clk: got %b want 0", u_dut.chip_rst); else n_pass++;
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_basic_write;
        int p0;
        p0 = wr_pulses;
        bus_cycle(1'b1, 8'hFF);
        n_checks++; if (wr_pulses - p0 !== 0) $display("FAIL ctrl_no_write: got %0d pulses want 0", wr_pulses - p0); else n_pass++;
        p0 = wr_pulses;
        bus_cycle(1'b1, 8'h08);
        n_checks++; if (wr_pulses - p0 !== 1) $display("FAIL addr_pulse: got %0d pulses want 1", wr_pulses - p0); else n_pass++;
        p0 = wr_pulses;
        bus_cycle(1'b0, 8'h0F);
        n_checks++; if (wr_pulses - p0 !== 1) $display("FAIL data_pulse: got %0d pulses want 1", wr_pulses - p0); else n_pass++;
        n_checks++; if (do4 !== 8'h0F) $display("FAIL basic_do: got %h want 0f", do4); else n_pass++;
        n_checks++; if (do2 !== 8'h0F) $display("FAIL basic_do2: got %h want 0f", do2); else n_pass++;
    endtask

    task automatic test_sel4;
        bus_cycle(1'b1, 8'hF6);
        bus_cycle(1'b1, 8'hFE);
        n_checks++; if (u_dut.sel_q !== 2'b11) $display("FAIL sel_3: got %b want 11", u_dut.sel_q); else n_pass++;
        wr_reg(8'h07, 8'h5A);
        n_checks++; if (do4 !== 8'h5A) $display("FAIL sel3_do: got %h want 5a", do4); else n_pass++;
        n_checks++; if (do2 !== 8'h5A) $display("FAIL sel_sat_do2: got %h want 5a", do2); else n_pass++;
        bus_cycle(1'b1, 8'hFF);
        n_checks++; if (do4 !== 8'h00) $display("FAIL chip2_untouched: got %h want 00", do4); else n_pass++;
        n_checks++; if (do2 !== 8'h0F) $display("FAIL sel1_masked_do2: got %h want 0f", do2); else n_pass++;
        bus_cycle(1'b1, 8'hF1);
        n_checks++; if (do4 !== 8'h0F) $display("FAIL chip0_do: got %h want 0f", do4); else n_pass++;
    endtask

    task automatic test_fm_gate;
        int p0;
        int exp_p;
        logic [7:0] exp_do;
`ifdef TURBOSOUND_FM_EN
        exp_p = 2;
        exp_do = 8'h77;
`else
        exp_p = 0;
        exp_do = 8'h0F;
`endif
        bus_cycle(1'b1, 8'hFF);
        p0 = wr_pulses;
        wr_reg(8'h28, 8'h99);
        n_checks++; if (wr_pulses - p0 !== 0) $display("FAIL fm_off_block: got %0d pulses want 0", wr_pulses - p0); else n_pass++;
        n_checks++; if (do4 !== 8'h0F) $display("FAIL fm_off_do: got %h want 0f", do4); else n_pass++;
        bus_cycle(1'b1, 8'hFB);
        p0 = wr_pulses;
        wr_reg(8'h28, 8'h77);
        n_checks++; if (wr_pulses - p0 !== exp_p) $display("FAIL fm_on_pulses: got %0d want %0d", wr_pulses - p0, exp_p); else n_pass++;
        n_checks++; if (do4 !== exp_do) $display("FAIL fm_on_do: got %h want %h", do4, exp_do); else n_pass++;
        bus_cycle(1'b1, 8'hFF);
    endtask

    task automatic test_saturation;
        logic seen;
        bus_cycle(1'b1, 8'hF1);
        wr_reg(8'h08, 8'hC0);
        n_checks++; if (l4 !== 12'h180) $display("FAIL one_chip_l: got %h want 180", l4); else n_pass++;
        bus_cycle(1'b1, 8'hFE);
        bus_cycle(1'b1, 8'h08);
        @(negedge CLK);
        BC = 1'b0;
        DI = 8'hC0;
        repeat (2) @(negedge CLK);
        BDIR = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            if (u_dut.psg_a[1] === 8'hC0) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b1) $display("FAIL psg_a1_timeout: got %b want 1", seen); else n_pass++;
        if (seen) begin
            repeat (3) @(negedge CLK);
            n_checks++; if (l4 !== 12'h180) $display("FAIL latency_early: got %h want 180", l4); else n_pass++;
            @(negedge CLK);
            n_checks++; if (l4 !== 12'h1FE) $display("FAIL latency_4clk: got %h want 1fe", l4); else n_pass++;
        end
        BDIR = 1'b0;
        repeat (8) @(negedge CLK);
        n_checks++; if (r4 !== 12'h000) $display("FAIL sat_r: got %h want 000", r4); else n_pass++;
        n_checks++; if (l2 !== 16'h01FE) $display("FAIL sat_l2: got %h want 01fe", l2); else n_pass++;
    endtask

    task automatic test_pan;
        logic [7:0]  ctl   [4] = '{8'hF1, 8'hF3, 8'hF5, 8'hF7};
        logic [11:0] exp_l [4] = '{12'h040, 12'h050, 12'h060, 12'h040};
        logic [11:0] exp_r [4] = '{12'h080, 12'h070, 12'h060, 12'h080};
        wr_reg(8'h08, 8'h00);
        bus_cycle(1'b1, 8'hFF);
        wr_reg(8'h08, 8'h10);
        wr_reg(8'h09, 8'h20);
        wr_reg(8'h0A, 8'h30);
        for (int i = 0; i < 4; i++) begin
            bus_cycle(1'b1, ctl[i]);
            n_checks++; if (l4 !== exp_l[i]) $display("FAIL pan%0d_l: got %h want %h", i, l4, exp_l[i]); else n_pass++;
            n_checks++; if (r4 !== exp_r[i]) $display("FAIL pan%0d_r: got %h want %h", i, r4, exp_r[i]); else n_pass++;
        end
        n_checks++; if (r2 !== 16'h0080) $display("FAIL pan_r2: got %h want 0080", r2); else n_pass++;
    endtask

    task automatic test_fm_mix;
        logic [11:0] exp_l;
        logic [15:0] exp_l2;
`ifdef TURBOSOUND_FM_EN
        exp_l  = 12'hC30;
        exp_l2 = 16'hFC30;
`else
        exp_l  = 12'h030;
        exp_l2 = 16'h0030;
`endif
        bus_cycle(1'b1, 8'hF5);
        wr_reg(8'h09, 8'h10);
        wr_reg(8'h0A, 8'h10);
        n_checks++; if (l4 !== 12'h030) $display("FAIL mono_l: got %h want 030", l4); else n_pass++;
        n_checks++; if (r4 !== 12'h030) $display("FAIL mono_r: got %h want 030", r4); else n_pass++;
        bus_cycle(1'b1, 8'hFB);
        wr_reg(8'hB1, 8'h80);
        bus_cycle(1'b1, 8'hFA);
        wr_reg(8'hB1, 8'h80);
        n_checks++; if (l4 !== exp_l) $display("FAIL fm_l: got %h want %h", l4, exp_l); else n_pass++;
        n_checks++; if (r4 !== exp_l) $display("FAIL fm_r: got %h want %h", r4, exp_l); else n_pass++;
        n_checks++; if (l2 !== exp_l2) $display("FAIL fm_l2_sext: got %h want %h", l2, exp_l2); else n_pass++;
        bus_cycle(1'b1, 8'hFE);
        n_checks++; if (l4 !== 12'h030) $display("FAIL fm_disable_l: got %h want 030", l4); else n_pass++;
    endtask

    task automatic test_reset_mid_write;
        int p0;
        bus_cycle(1'b1, 8'h09);
        @(negedge CLK);
        RESET_N = 1'b0;
        repeat (3) @(negedge CLK);
        n_checks++; if (l4 !== 12'h000) $display("FAIL midrst_l: got %h want 000", l4); else n_pass++;
        n_checks++; if (r2 !== 16'h0000) $display("FAIL midrst_r2: got %h want 0000", r2); else n_pass++;
        n_checks++; if (do4 !== 8'h00) $display("FAIL midrst_do: got %h want 00", do4); else n_pass++;
        n_checks++; if (u_dut.sel_q !== 2'b00) $display("FAIL midrst_sel: got %b want 00", u_dut.sel_q); else n_pass++;
        n_checks++; if (u_dut.pan_q !== 2'b00) $display("FAIL midrst_pan: got %b want 00", u_dut.pan_q); else n_pass++;
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (4) @(negedge CLK);
        p0 = wr_pulses;
        bus_cycle(1'b0, 8'h44);
        n_checks++; if (wr_pulses - p0 !== 0) $display("FAIL midrst_no_write: got %0d pulses want 0", wr_pulses - p0); else n_pass++;
        n_checks++; if (do4 !== 8'h00) $display("FAIL midrst_do_after: got %h want 00", do4); else n_pass++;
        n_checks++; if (l4 !== 12'h000) $display("FAIL midrst_l_after: got %h want 000", l4); else n_pass++;
    endtask

    initial begin
        CE      = 1'b1;
        BDIR    = 1'b0;
        BC      = 1'b0;
        DI      = 8'h00;
        RESET_N = 1'b1;
        test_reset;
        test_basic_write;
        test_sel4;
        test_fm_gate;
        test_saturation;
        test_pan;
        test_fm_mix;
        test_reset_mid_write;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
